mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised registered N-channel multiplexer, the successor to the team's gate-level 4:1 mux.
- Manual mode: a registered mux driven by a select input.
- Scan mode: an autonomous time-division scanner that walks the channels with a programmable dwell time.
- Feeds a single shared downstream datapath, e.g. a serial/display/monitor stage, from several sources.

Parameters:
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels, must be >= 2
- SEL_W, $clog2(CHANNELS), select/pointer width (localparam, derived)
- DWELL, 4, cycles each channel is presented in scan mode, must be >= 1

Ports:
- clk  input  1  single clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- din  input  CHANNELS*WIDTH  packed channel data; channel i at din[i*WIDTH +: WIDTH]
- en  input  1  block enable; low = pause/hold
- mode  input  1  0 = manual, 1 = scan
- sel_in  input  SEL_W  manual-mode channel select
- dout  output  WIDTH  registered selected data
- dout_valid  output  1  dout updated this cycle with a legal channel
- cur_sel  output  SEL_W  channel currently shown on dout
- frame_start  output  1  one-cycle pulse on the first cycle of each scan sweep
- sel_err  output  1  one-cycle pulse when manual sel_in >= CHANNELS

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, named clk/rst as in the codebase.
  - On rst=1 at an edge: dout=0, dout_valid=0, cur_sel=0, frame_start=0, sel_err=0, scan pointer=0, dwell counter=0, state=IDLE.
  - rst has priority over all other inputs.
- FSM states are IDLE, MANUAL and SCAN. Next state is evaluated every edge:
  - en=0 -> IDLE
  - en=1, mode=0 -> MANUAL
  - en=1, mode=1 -> SCAN
- IDLE:
  - dout and cur_sel hold their last value; dout_valid=0, frame_start=0, sel_err=0.
  - Scan pointer and dwell counter hold, so a paused scan resumes exactly where it stopped.
- MANUAL:
  - Latency 1: dout <= din[sel_in], cur_sel <= sel_in, dout_valid <= 1.
  - If sel_in >= CHANNELS: dout holds, dout_valid <= 0, sel_err <= 1. Only possible when CHANNELS is not a power of 2.
  - Scan pointer and dwell counter are not modified.
- Entry into SCAN from MANUAL or from reset: pointer=0 and dwell counter=0.
- Entry into SCAN from IDLE: resumes, unless the previous active state was MANUAL, in which case it restarts at 0.
- SCAN, every cycle:
  - dout <= din[ptr], cur_sel <= ptr, dout_valid <= 1.
  - If cnt == DWELL-1: cnt <= 0 and ptr advances to the next channel, wrapping from CHANNELS-1 to 0. Otherwise cnt <= cnt+1.
  - frame_start <= 1 on the cycle dout first shows the sweep's first channel (ptr=0 with cnt=0); 0 otherwise.
- DWELL=1: ptr advances every cycle, and frame_start fires every CHANNELS cycles.
- din changes during a dwell are tracked: dout resamples every cycle, it is not latched once per dwell.
- Switching mode mid-dwell takes effect at the next edge with no bubble. dout_valid stays 1 if the new state produces legal data.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- When defined:
  - Adds input ch_en [CHANNELS].
  - In scan, ptr advances to the next channel with ch_en=1 (wrapping) and skips disabled channels.
  - frame_start marks the lowest-numbered enabled channel.
  - If the current ptr is disabled at dwell end or on entry, it moves to the next enabled channel.
  - If ch_en is all zero: dout holds, dout_valid=0, frame_start=0.
  - MANUAL mode ignores ch_en.
- When undefined: no ch_en port, and all channels are scanned.

Test Plan:
Common setup: CHANNELS=4, WIDTH=8, DWELL=2, din ch0..ch3 = A0, B1, C2, D3.
1. rst=1 for 2 cycles with en=1, mode=1 -> dout=00, dout_valid=0, cur_sel=0, frame_start=0, sel_err=0.
2. en=1, mode=0, sel_in=2 -> next edge dout=C2, cur_sel=2, dout_valid=1. Then sel_in=0 -> dout=A0 one cycle later.
3. en=1, mode=1 from reset -> dout sequence A0,A0,B1,B1,C2,C2,D3,D3,A0. frame_start=1 on cycle 1 and cycle 9 only.
4. Scan, drop en for 3 cycles after the first B1 cycle -> dout holds B1, dout_valid=0. On re-enable: B1 once, then C2,C2.
5. rst pulse while dout=C2 in scan, mode=1 kept -> cycle after reset dout=00. Then A0 with frame_start=1.
6. MUX_SCAN_MASK_EN, ch_en=4'b0101 -> A0,A0,C2,C2,A0. ch_en=0 -> dout_valid=0, dout held.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered N-channel mux: manual select, or autonomous scan with programmable dwell.
// Latency: 1 cycle from din/sel_in (or scan pointer) to dout/cur_sel/dout_valid.
// No backpressure: en=0 pauses (outputs hold, dout_valid=0); optional MUX_SCAN_MASK_EN adds ch_en skip mask.
module mux_scan_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       ch_en,
`endif
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      frame_start,
    output logic                      sel_err
);

    // FSM encoding; the state is a pure function of en/mode sampled at each edge
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    // Dwell counter only needs to reach DWELL-1; keep at least one bit for DWELL=1
    localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    // One extra bit so a select value equal to CHANNELS is representable
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic [1:0]       state_q, state_d;
    logic             last_man_q, last_man_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             frame_start_q, frame_start_d;
    logic             sel_err_q, sel_err_d;

    // Resolved scan position for the current edge
    logic             restart;
    logic [SEL_W-1:0] base_ptr;
    logic [CNT_W-1:0] base_cnt;
    logic [SEL_W-1:0] eff_ptr;
    logic [CNT_W-1:0] eff_cnt;
    logic [SEL_W-1:0] next_ptr;
    logic [SEL_W-1:0] first_ch;
    logic             scan_live;

    // Select one channel out of the packed bus; out-of-range indices yield zero
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0]          idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == SEL_W'(i)) begin
                r = bus[i*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // Next channel with wrap from the last channel back to 0
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] p);
        return (p == LAST_CH) ? '0 : p + SEL_W'(1);
    endfunction

`ifdef MUX_SCAN_MASK_EN
    // True when channel p is enabled in the mask
    function automatic logic chan_on(input logic [CHANNELS-1:0] mask,
                                     input logic [SEL_W-1:0]    p);
        return (mask & (CHANNELS'(1) << p)) != '0;
    endfunction

    // First enabled channel at or after start (or strictly after when skip_self),
    // searching cyclically; returns start when nothing is enabled
    function automatic logic [SEL_W-1:0] find_en(input logic [SEL_W-1:0]    start,
                                                 input logic [CHANNELS-1:0] mask,
                                                 input logic                skip_self);
        logic [SEL_W-1:0] cand;
        logic [SEL_W-1:0] r;
        logic             found;
        cand  = skip_self ? wrap_inc(start) : start;
        r     = start;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && chan_on(mask, cand)) begin
                r     = cand;
                found = 1'b1;
            end
            cand = wrap_inc(cand);
        end
        return r;
    endfunction
`endif

    // Resolve where the scanner stands this edge: restart after manual, then skip disabled channels
    always_comb begin
        // Entering scan after manual (directly or via a pause) restarts the sweep
        restart  = (state_q == ST_MANUAL) || last_man_q;
        base_ptr = restart ? '0 : ptr_q;
        base_cnt = restart ? '0 : cnt_q;
`ifdef MUX_SCAN_MASK_EN
        scan_live = |ch_en;
        first_ch  = find_en('0, ch_en, 1'b0);
        if (chan_on(ch_en, base_ptr)) begin
            eff_ptr = base_ptr;
            eff_cnt = base_cnt;
        end else begin
            // Parked on a disabled channel: jump forward and start a fresh dwell
            eff_ptr = find_en(base_ptr, ch_en, 1'b1);
            eff_cnt = '0;
        end
        next_ptr = find_en(eff_ptr, ch_en, 1'b1);
`else
        scan_live = 1'b1;
        first_ch  = '0;
        eff_ptr   = base_ptr;
        eff_cnt   = base_cnt;
        next_ptr  = wrap_inc(eff_ptr);
`endif
    end

    // Next-state and output computation for the three modes
    always_comb begin
        state_d       = en ? (mode ? ST_SCAN : ST_MANUAL) : ST_IDLE;
        last_man_d    = last_man_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        dout_d        = dout_q;
        cur_sel_d     = cur_sel_q;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        sel_err_d     = 1'b0;

        case (state_d)
            ST_MANUAL: begin
                // Scan position untouched; only remember that manual ran last
                last_man_d = 1'b1;
                if ({1'b0, sel_in} < CH_LIMIT) begin
                    dout_d       = pick(din, sel_in);
                    cur_sel_d    = sel_in;
                    dout_valid_d = 1'b1;
                end else begin
                    sel_err_d = 1'b1;
                end
            end
            ST_SCAN: begin
                last_man_d = 1'b0;
                // Commit any restart even if nothing can be shown this cycle
                ptr_d      = base_ptr;
                cnt_d      = base_cnt;
                if (scan_live) begin
                    dout_d        = pick(din, eff_ptr);
                    cur_sel_d     = eff_ptr;
                    dout_valid_d  = 1'b1;
                    frame_start_d = (eff_ptr == first_ch) && (eff_cnt == '0);
                    if (eff_cnt == CNT_LAST) begin
                        cnt_d = '0;
                        ptr_d = next_ptr;
                    end else begin
                        cnt_d = eff_cnt + CNT_W'(1);
                        ptr_d = eff_ptr;
                    end
                end
            end
            default: begin
                // Paused: everything holds, valid/pulse outputs drop
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_man_q    <= 1'b0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            cur_sel_q     <= '0;
            frame_start_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_man_q    <= last_man_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            cur_sel_q     <= cur_sel_d;
            frame_start_q <= frame_start_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign cur_sel     = cur_sel_q;
    assign frame_start = frame_start_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: two instances (4ch/dwell2 and 3ch/dwell1) against a behavioural model.
// Latency: model updated at each rising edge, outputs compared 1 time unit later.
// Stimulus: directed literal sequences, then randomized en/mode/sel/din/rst.
module tb_mux_scan_n;

    logic       clk = 1'b0;
    logic       rst, en, mode;
    logic [31:0] din0;
    logic [23:0] din3;
    logic [1:0] sel0, sel3;
    logic [3:0] ch_en0;
    logic [2:0] ch_en3;

    logic [7:0] dout0, dout3;
    logic       val0, val3, fs0, fs3, err0, err3;
    logic [1:0] cur0, cur3;

    int checks   = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    // Model state per instance (0: 4 channels dwell 2, 1: 3 channels dwell 1)
    logic [7:0] m_dout[2];
    logic       m_valid[2], m_fs[2], m_err[2], m_restart[2];
    int         m_ptr[2], m_cnt[2], m_cur[2];

    always #5 clk = ~clk;

    mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .en(en), .mode(mode), .sel_in(sel0),
`ifdef MUX_SCAN_MASK_EN
        .ch_en(ch_en0),
`endif
        .dout(dout0), .dout_valid(val0), .cur_sel(cur0), .frame_start(fs0), .sel_err(err0)
    );

    mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_dut3 (
        .clk(clk), .rst(rst), .din(din3), .en(en), .mode(mode), .sel_in(sel3),
`ifdef MUX_SCAN_MASK_EN
        .ch_en(ch_en3),
`endif
        .dout(dout3), .dout_valid(val3), .cur_sel(cur3), .frame_start(fs3), .sel_err(err3)
    );

    function automatic logic [7:0] chan(input int k, input int i);
        return (k == 0) ? din0[i*8 +: 8] : din3[i*8 +: 8];
    endfunction

    function automatic int next_on(input int p, input logic [3:0] msk, input int nch);
        for (int j = 1; j <= nch; j++) begin
            if (msk[(p + j) % nch]) return (p + j) % nch;
        end
        return p;
    endfunction

    function automatic int lowest_on(input logic [3:0] msk, input int nch);
        for (int i = 0; i < nch; i++) begin
            if (msk[i]) return i;
        end
        return 0;
    endfunction

    // One clock edge of the reference behaviour
    task automatic model_step(input int k);
        int nch, dw, sel;
        logic [3:0] msk;
        nch = (k == 0) ? 4 : 3;
        dw  = (k == 0) ? 2 : 1;
        sel = (k == 0) ? int'(sel0) : int'(sel3);
        msk = (k == 0) ? ch_en0 : {1'b0, ch_en3};
        if (rst) begin
            m_dout[k] = 8'h00; m_valid[k] = 1'b0; m_cur[k] = 0; m_fs[k] = 1'b0;
            m_err[k] = 1'b0; m_ptr[k] = 0; m_cnt[k] = 0; m_restart[k] = 1'b0;
        end else if (!en) begin
            m_valid[k] = 1'b0; m_fs[k] = 1'b0; m_err[k] = 1'b0;
        end else if (!mode) begin
            m_fs[k] = 1'b0;
            m_restart[k] = 1'b1;
            if (sel < nch) begin
                m_dout[k] = chan(k, sel); m_cur[k] = sel; m_valid[k] = 1'b1; m_err[k] = 1'b0;
            end else begin
                m_valid[k] = 1'b0; m_err[k] = 1'b1;
            end
        end else begin
            m_err[k] = 1'b0;
            if (m_restart[k]) begin
                m_ptr[k] = 0; m_cnt[k] = 0; m_restart[k] = 1'b0;
            end
            if (msk == 4'h0) begin
                m_valid[k] = 1'b0; m_fs[k] = 1'b0;
            end else begin
                if (!msk[m_ptr[k]]) begin
                    m_ptr[k] = next_on(m_ptr[k], msk, nch);
                    m_cnt[k] = 0;
                end
                m_dout[k]  = chan(k, m_ptr[k]);
                m_cur[k]   = m_ptr[k];
                m_valid[k] = 1'b1;
                m_fs[k]    = (m_ptr[k] == lowest_on(msk, nch)) && (m_cnt[k] == 0);
                if (m_cnt[k] == dw - 1) begin
                    m_cnt[k] = 0;
                    m_ptr[k] = next_on(m_ptr[k], msk, nch);
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    endtask

    task automatic cmp(input int k, input logic [7:0] d, input logic v, input logic [1:0] c,
                       input logic f, input logic e);
        checks++;
        if (d !== m_dout[k] || v !== m_valid[k] || c !== 2'(m_cur[k]) || f !== m_fs[k] || e !== m_err[k]) begin
            failures++;
            $display("FAIL model_i%0d t=%0t got dout=%h vld=%b sel=%0d fs=%b err=%b want dout=%h vld=%b sel=%0d fs=%b err=%b",
                     k, $time, d, v, c, f, e, m_dout[k], m_valid[k], m_cur[k], m_fs[k], m_err[k]);
        end
    endtask

    // Compare process: step the model at every edge and check both instances shortly after
    initial begin
        forever begin
            @(posedge clk);
            if (rst) chk_on = 1'b1;
            model_step(0);
            model_step(1);
            #1;
            if (chk_on) begin
                cmp(0, dout0, val0, cur0, fs0, err0);
                cmp(1, dout3, val3, cur3, fs3, err3);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] seq0[9];
    logic [7:0] seq3[4];

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b1;
        din0 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        din3 = {8'h33, 8'h22, 8'h11};
        sel0 = 2'd0; sel3 = 2'd0;
        ch_en0 = 4'hF; ch_en3 = 3'h7;
        seq0 = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hA0};
        seq3 = '{8'h11, 8'h22, 8'h33, 8'h11};

        // Reset held two cycles with scan requested
        cyc(); cyc();
        lit("rst_dout", 32'(dout0), 32'h00);
        lit("rst_vld", 32'(val0), 32'h0);
        lit("rst_sel", 32'(cur0), 32'h0);
        lit("rst_fs", 32'(fs0), 32'h0);
        lit("rst_err", 32'(err0), 32'h0);

        // Manual select
        rst = 1'b0; mode = 1'b0; sel0 = 2'd2;
        cyc();
        lit("man_dout2", 32'(dout0), 32'hC2);
        lit("man_sel2", 32'(cur0), 32'h2);
        lit("man_vld", 32'(val0), 32'h1);
        sel0 = 2'd0;
        cyc();
        lit("man_dout0", 32'(dout0), 32'hA0);

        // Scan sweep from reset
        rst = 1'b1; cyc();
        rst = 1'b0; mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            lit("scan_dout", 32'(dout0), 32'(seq0[i]));
            lit("scan_fs", 32'(fs0), 32'((i == 0) || (i == 8)));
            if (i < 4) begin
                lit("scan1_dout", 32'(dout3), 32'(seq3[i]));
                lit("scan1_fs", 32'(fs3), 32'(i % 3 == 0));
            end
        end

        // Pause after the first B1 cycle, then resume
        rst = 1'b1; cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        lit("pre_pause", 32'(dout0), 32'hB1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            lit("pause_dout", 32'(dout0), 32'hB1);
            lit("pause_vld", 32'(val0), 32'h0);
        end
        en = 1'b1;
        cyc(); lit("resume_b1", 32'(dout0), 32'hB1);
        cyc(); lit("resume_c2a", 32'(dout0), 32'hC2);
        cyc(); lit("resume_c2b", 32'(dout0), 32'hC2);

        // Reset pulse mid-scan
        rst = 1'b1; cyc();
        lit("rst_mid_dout", 32'(dout0), 32'h00);
        rst = 1'b0; cyc();
        lit("post_rst_dout", 32'(dout0), 32'hA0);
        lit("post_rst_fs", 32'(fs0), 32'h1);

        // Manual interlude restarts the sweep, directly and through a pause
        cyc(); cyc();
        lit("pre_man_b1", 32'(dout0), 32'hB1);
        mode = 1'b0; sel0 = 2'd3; cyc();
        lit("man_d3", 32'(dout0), 32'hD3);
        mode = 1'b1; cyc();
        lit("restart_a0", 32'(dout0), 32'hA0);
        lit("restart_fs", 32'(fs0), 32'h1);
        cyc(); cyc();
        mode = 1'b0; sel0 = 2'd1; cyc();
        en = 1'b0; cyc();
        en = 1'b1; mode = 1'b1; cyc();
        lit("idle_restart_a0", 32'(dout0), 32'hA0);
        lit("idle_restart_fs", 32'(fs0), 32'h1);
        en = 1'b0; cyc();
        en = 1'b1; cyc();
        lit("idle_resume_a0", 32'(dout0), 32'hA0);
        lit("idle_resume_fs", 32'(fs0), 32'h0);
        cyc();
        lit("idle_resume_b1", 32'(dout0), 32'hB1);

        // Illegal manual select on the 3-channel instance
        mode = 1'b0; sel3 = 2'd3; cyc();
        lit("selerr_pulse", 32'(err3), 32'h1);
        lit("selerr_vld", 32'(val3), 32'h0);
        sel3 = 2'd1; cyc();
        lit("selerr_clear", 32'(err3), 32'h0);
        lit("selerr_dout", 32'(dout3), 32'h22);

`ifdef MUX_SCAN_MASK_EN
        // Masked scan skips disabled channels; an empty mask stalls the output
        rst = 1'b1; mode = 1'b1; ch_en0 = 4'b0101; cyc();
        rst = 1'b0;
        seq0 = '{8'hA0, 8'hA0, 8'hC2, 8'hC2, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            cyc();
            lit("mask_dout", 32'(dout0), 32'(seq0[i]));
        end
        ch_en0 = 4'b0000; cyc();
        lit("mask_zero_vld", 32'(val0), 32'h0);
        lit("mask_zero_dout", 32'(dout0), 32'hA0);
        ch_en0 = 4'hF;
`endif

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel0 = 2'($urandom_range(0, 3));
            sel3 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) din0 = $urandom;
            if ($urandom_range(0, 3) == 0) din3 = 24'($urandom);
`ifdef MUX_SCAN_MASK_EN
            if ($urandom_range(0, 15) == 0) ch_en0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) ch_en3 = 3'($urandom_range(0, 7));
`endif
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
